// File: rtl/dsa_bilinear_engine_n.sv
// dsa_bilinear_engine_n
//   Bilinear resampler for an 8-bit grayscale image held in a shared byte
//   memory. Destination pixels are produced in groups of 1 (mode_simd=0) or
//   LANES (mode_simd=1). Each active lane fetches four neighbours, the group
//   is interpolated in one cycle and then written back lane 0 first.
//
//   Optional build macro DSA_PERF_CNT_EN: when defined, flops_count,
//   reads_count and writes_count are live; otherwise they are tied to 0.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start, abort             frame start (IDLE only) / frame termination
//   mode_simd                group size select, latched at start
//   src_width, src_height    source dimensions, latched at start
//   dst_width, dst_height    destination dimensions, latched at start
//   step_x, step_y           Q8.8 source step per destination pixel
//   mem_req/we/addr/wdata    memory request, held until mem_gnt
//   mem_gnt, mem_rdata       grant; read data valid the cycle after a granted read
//   busy, done, progress     status; progress = destination rows completed
//   flops/reads/writes_count performance counters
module dsa_bilinear_engine_n #(
   parameter int unsigned ADDR_WIDTH = 18,
   parameter int unsigned LANES      = 4,
   parameter int unsigned DIM_WIDTH  = 16,
   parameter int unsigned SRC_BASE   = 0,
   parameter int unsigned DST_BASE   = 131072
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  mode_simd,
   input  logic [DIM_WIDTH-1:0]  src_width,
   input  logic [DIM_WIDTH-1:0]  src_height,
   input  logic [DIM_WIDTH-1:0]  dst_width,
   input  logic [DIM_WIDTH-1:0]  dst_height,
   input  logic [15:0]           step_x,
   input  logic [15:0]           step_y,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [7:0]            mem_wdata,
   input  logic                  mem_gnt,
   input  logic [7:0]            mem_rdata,
   output logic                  busy,
   output logic                  done,
   output logic [DIM_WIDTH-1:0]  progress,
   output logic [31:0]           flops_count,
   output logic [31:0]           reads_count,
   output logic [31:0]           writes_count
);

   localparam int unsigned IW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned CW = $clog2(LANES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_FETCH, S_WAIT, S_COMPUTE, S_WRITE, S_NEXT, S_DONE
   } state_t;

   state_t                state_q;
   logic                  simd_q;
   logic [DIM_WIDTH-1:0]  src_w_q, src_h_q, dst_w_q, dst_h_q;
   logic [15:0]           step_x_q, step_y_q;
   logic [DIM_WIDTH-1:0]  x_q, y_q, progress_q;
   logic [DIM_WIDTH-1:0]  x0_q [LANES];
   logic [DIM_WIDTH-1:0]  x1_q [LANES];
   logic [7:0]            fx_q [LANES];
   logic [7:0]            fy_q;
   logic [ADDR_WIDTH-1:0] row0_q, row1_q, dst_row_q;
   logic [CW-1:0]         n_act_q;
   logic [IW-1:0]         lane_q, rd_lane_q;
   logic [1:0]            sub_q, rd_sub_q;
   logic                  rd_pend_q;
   logic [7:0]            pix_q [LANES][4];
   logic [7:0]            out_q [LANES];
   logic                  mem_req_q, mem_we_q, done_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [7:0]            mem_wdata_q;

   // Combinational helpers
   logic [DIM_WIDTH-1:0]  xmax_c, ymax_c;
   logic [23:0]           sx_c [LANES];
   logic [DIM_WIDTH-1:0]  cx0_c [LANES];
   logic [DIM_WIDTH-1:0]  cx1_c [LANES];
   logic [7:0]            cfx_c [LANES];
   logic [23:0]           sy_c;
   logic [DIM_WIDTH-1:0]  cy0_c, cy1_c;
   logic [ADDR_WIDTH-1:0] row0_c, row1_c, dst_row_c;
   logic [31:0]           grp_c, rem_c, x_adv_c;
   logic [CW-1:0]         n_act_c;
   logic [7:0]            out_c [LANES];
   logic [IW-1:0]         lane_n_c;
   logic [1:0]            sub_n_c;
   logic                  last_lane_c, row_end_c, last_row_c;
   logic [ADDR_WIDTH-1:0] fetch_first_c, fetch_next_c, wr_first_c, wr_next_c;

   function automatic logic [DIM_WIDTH-1:0] clamp_coord(input logic [15:0] raw,
                                                       input logic [DIM_WIDTH-1:0] maxc);
      if (32'(raw) > 32'(maxc)) return maxc;
      return DIM_WIDTH'(raw);
   endfunction

   function automatic logic [DIM_WIDTH-1:0] next_coord(input logic [DIM_WIDTH-1:0] c,
                                                      input logic [DIM_WIDTH-1:0] maxc);
      if (32'(c) + 32'd1 > 32'(maxc)) return maxc;
      return c + 1'b1;
   endfunction

   function automatic logic [7:0] interp(input logic [7:0] p00, input logic [7:0] p01,
                                         input logic [7:0] p10, input logic [7:0] p11,
                                         input logic [7:0] fx, input logic [7:0] fy);
      logic [31:0] wx1, wx0, wy1, wy0, top, bot, acc;
      wx1 = 32'(fx);
      wx0 = 32'd256 - wx1;
      wy1 = 32'(fy);
      wy0 = 32'd256 - wy1;
      top = 32'(p00) * wx0 + 32'(p01) * wx1;
      bot = 32'(p10) * wx0 + 32'(p11) * wx1;
      acc = (top * wy0 + bot * wy1 + 32'd32768) >> 16;
      if (acc > 32'd255) return 8'hFF;
      return acc[7:0];
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] src_addr(input logic [ADDR_WIDTH-1:0] row,
                                                     input logic [DIM_WIDTH-1:0] col);
      return ADDR_WIDTH'(SRC_BASE) + row + ADDR_WIDTH'(col);
   endfunction

   assign xmax_c = src_w_q - 1'b1;
   assign ymax_c = src_h_q - 1'b1;

   // Coordinates for the group starting at (x_q, y_q); registered in SETUP.
   // Only bits [23:0] of the 32-bit step product are ever used.
   always_comb begin
      for (int unsigned l = 0; l < LANES; l++) begin
         sx_c[l]  = 24'((32'(x_q) + l) * 32'(step_x_q));
         cx0_c[l] = clamp_coord(sx_c[l][23:8], xmax_c);
         cx1_c[l] = next_coord(cx0_c[l], xmax_c);
         cfx_c[l] = sx_c[l][7:0];
      end
      sy_c  = 24'(32'(y_q) * 32'(step_y_q));
      cy0_c = clamp_coord(sy_c[23:8], ymax_c);
      cy1_c = next_coord(cy0_c, ymax_c);
   end

   assign row0_c    = ADDR_WIDTH'(32'(cy0_c) * 32'(src_w_q));
   assign row1_c    = ADDR_WIDTH'(32'(cy1_c) * 32'(src_w_q));
   assign dst_row_c = ADDR_WIDTH'(32'(y_q) * 32'(dst_w_q));

   // Active lanes are always a contiguous run starting at lane 0.
   assign grp_c   = simd_q ? LANES : 32'd1;
   assign rem_c   = 32'(dst_w_q) - 32'(x_q);
   assign n_act_c = CW'((rem_c < grp_c) ? rem_c : grp_c);

   always_comb begin
      for (int unsigned l = 0; l < LANES; l++) begin
         out_c[l] = interp(pix_q[l][0], pix_q[l][1], pix_q[l][2], pix_q[l][3], fx_q[l], fy_q);
      end
   end

   assign lane_n_c    = lane_q + 1'b1;
   assign sub_n_c     = sub_q + 2'd1;
   assign last_lane_c = (32'(lane_q) + 32'd1 == 32'(n_act_q));
   assign x_adv_c     = 32'(x_q) + grp_c;
   assign row_end_c   = (x_adv_c >= 32'(dst_w_q));
   assign last_row_c  = (32'(y_q) + 32'd1 >= 32'(dst_h_q));

   // Neighbour order per lane: p00, p01, p10, p11 (sub[1] = row, sub[0] = column).
   assign fetch_first_c = src_addr(row0_c, cx0_c[0]);
   always_comb begin
      if (sub_q == 2'd3) begin
         fetch_next_c = src_addr(row0_q, x0_q[lane_n_c]);
      end else begin
         fetch_next_c = src_addr(sub_n_c[1] ? row1_q : row0_q,
                                 sub_n_c[0] ? x1_q[lane_q] : x0_q[lane_q]);
      end
   end
   assign wr_first_c = ADDR_WIDTH'(DST_BASE) + dst_row_q + ADDR_WIDTH'(x_q);
   assign wr_next_c  = wr_first_c + ADDR_WIDTH'(lane_n_c);

`ifdef DSA_PERF_CNT_EN
   logic [31:0] flops_q, reads_q, writes_q;
   assign flops_count  = flops_q;
   assign reads_count  = reads_q;
   assign writes_count = writes_q;
`else
   assign flops_count  = '0;
   assign reads_count  = '0;
   assign writes_count = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         simd_q      <= 1'b0;
         src_w_q     <= '0;
         src_h_q     <= '0;
         dst_w_q     <= '0;
         dst_h_q     <= '0;
         step_x_q    <= '0;
         step_y_q    <= '0;
         x_q         <= '0;
         y_q         <= '0;
         progress_q  <= '0;
         fy_q        <= '0;
         row0_q      <= '0;
         row1_q      <= '0;
         dst_row_q   <= '0;
         n_act_q     <= '0;
         lane_q      <= '0;
         sub_q       <= '0;
         rd_lane_q   <= '0;
         rd_sub_q    <= '0;
         rd_pend_q   <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         done_q      <= 1'b0;
         for (int unsigned l = 0; l < LANES; l++) begin
            x0_q[l]  <= '0;
            x1_q[l]  <= '0;
            fx_q[l]  <= '0;
            out_q[l] <= '0;
            for (int unsigned k = 0; k < 4; k++) pix_q[l][k] <= '0;
         end
`ifdef DSA_PERF_CNT_EN
         flops_q  <= '0;
         reads_q  <= '0;
         writes_q <= '0;
`endif
      end else begin
         done_q    <= 1'b0;
         rd_pend_q <= 1'b0;
         // Read data belongs to the access granted on the previous cycle.
         if (rd_pend_q) pix_q[rd_lane_q][rd_sub_q] <= mem_rdata;

         if (abort) begin
            state_q   <= S_IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start) begin
                     simd_q     <= mode_simd;
                     src_w_q    <= src_width;
                     src_h_q    <= src_height;
                     dst_w_q    <= dst_width;
                     dst_h_q    <= dst_height;
                     step_x_q   <= step_x;
                     step_y_q   <= step_y;
                     x_q        <= '0;
                     y_q        <= '0;
                     progress_q <= '0;
                     state_q    <= (dst_width != '0 && dst_height != '0) ? S_SETUP : S_DONE;
                  end
               end
               S_SETUP: begin
                  for (int unsigned l = 0; l < LANES; l++) begin
                     x0_q[l] <= cx0_c[l];
                     x1_q[l] <= cx1_c[l];
                     fx_q[l] <= cfx_c[l];
                  end
                  fy_q       <= sy_c[7:0];
                  row0_q     <= row0_c;
                  row1_q     <= row1_c;
                  dst_row_q  <= dst_row_c;
                  n_act_q    <= n_act_c;
                  lane_q     <= '0;
                  sub_q      <= '0;
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= fetch_first_c;
                  state_q    <= S_FETCH;
               end
               S_FETCH: begin
                  if (mem_gnt) begin
                     rd_pend_q <= 1'b1;
                     rd_lane_q <= lane_q;
                     rd_sub_q  <= sub_q;
`ifdef DSA_PERF_CNT_EN
                     reads_q   <= reads_q + 32'd1;
`endif
                     if (sub_q == 2'd3 && last_lane_c) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_WAIT;
                     end else begin
                        if (sub_q == 2'd3) lane_q <= lane_n_c;
                        sub_q      <= sub_n_c;
                        mem_addr_q <= fetch_next_c;
                     end
                  end
               end
               S_WAIT: begin
                  state_q <= S_COMPUTE;
               end
               S_COMPUTE: begin
                  for (int unsigned l = 0; l < LANES; l++) out_q[l] <= out_c[l];
`ifdef DSA_PERF_CNT_EN
                  flops_q     <= flops_q + (32'(n_act_q) << 3);
`endif
                  lane_q      <= '0;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= wr_first_c;
                  mem_wdata_q <= out_c[0];
                  state_q     <= S_WRITE;
               end
               S_WRITE: begin
                  if (mem_gnt) begin
`ifdef DSA_PERF_CNT_EN
                     writes_q <= writes_q + 32'd1;
`endif
                     if (last_lane_c) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= S_NEXT;
                     end else begin
                        lane_q      <= lane_n_c;
                        mem_addr_q  <= wr_next_c;
                        mem_wdata_q <= out_q[lane_n_c];
                     end
                  end
               end
               S_NEXT: begin
                  if (row_end_c) begin
                     x_q        <= '0;
                     y_q        <= y_q + 1'b1;
                     progress_q <= progress_q + 1'b1;
                     state_q    <= last_row_c ? S_DONE : S_SETUP;
                  end else begin
                     x_q     <= DIM_WIDTH'(x_adv_c);
                     state_q <= S_SETUP;
                  end
               end
               S_DONE: begin
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign progress  = progress_q;

endmodule

// File: tb/tb_dsa_bilinear_engine_n.sv
// Scoreboard bench for dsa_bilinear_engine_n: expected destination writes are
// queued before each frame and popped by a monitor on every granted write.
module tb_dsa_bilinear_engine_n;

   localparam int unsigned AW   = 18;
   localparam int unsigned LN   = 4;
   localparam int unsigned DW   = 16;
   localparam int unsigned DSTB = 131072;
`ifdef DSA_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic          clk, rst, start, abort, mode_simd;
   logic [DW-1:0] src_width, src_height, dst_width, dst_height;
   logic [15:0]   step_x, step_y;
   logic          mem_req, mem_we, mem_gnt;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata, mem_rdata;
   logic          busy, done;
   logic [DW-1:0] progress;
   logic [31:0]   flops_count, reads_count, writes_count;

   dsa_bilinear_engine_n #(
      .ADDR_WIDTH(AW), .LANES(LN), .DIM_WIDTH(DW), .SRC_BASE(0), .DST_BASE(DSTB)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .mode_simd(mode_simd),
      .src_width(src_width), .src_height(src_height),
      .dst_width(dst_width), .dst_height(dst_height),
      .step_x(step_x), .step_y(step_y),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
      .busy(busy), .done(done), .progress(progress),
      .flops_count(flops_count), .reads_count(reads_count), .writes_count(writes_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] a;
      logic [7:0]    d;
   } wr_t;

   wr_t        exp_q[$];
   logic [7:0] mem [0:(1<<AW)-1];
   int         total = 0;
   int         bad = 0;
   int         obs_rd = 0, obs_wr = 0, req_seen = 0, done_seen = 0;
   bit         stall_en = 1'b0;
   int         basic_vals[9] = '{10, 15, 20, 20, 25, 30, 30, 35, 40};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_wr(input int off, input int d);
      wr_t w;
      w.a = AW'(DSTB + off);
      w.d = 8'(d);
      exp_q.push_back(w);
   endtask

   // Grant generator: always granted, or alternating when stalling.
   initial begin
      mem_gnt = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         mem_gnt = stall_en ? ~mem_gnt : 1'b1;
      end
   end

   // Memory model: read data appears the cycle after a granted read.
   initial begin
      logic          mv, mw;
      logic [AW-1:0] ma;
      logic [7:0]    md;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         mv = mem_req && mem_gnt;
         mw = mem_we;
         ma = mem_addr;
         md = mem_wdata;
         @(posedge clk);
         #1;
         if (mv) begin
            if (mw) mem[ma] = md;
            else    mem_rdata = mem[ma];
         end
      end
   end

   // Monitor: scoreboard on writes, access counting, hold-while-stalled checks.
   initial begin
      logic          p_pend;
      logic [AW-1:0] p_addr;
      logic          p_we;
      logic [7:0]    p_wd;
      wr_t           e;
      p_pend = 1'b0;
      p_addr = '0;
      p_we   = 1'b0;
      p_wd   = '0;
      forever begin
         @(negedge clk);
         if (p_pend) begin
            chk("hold_req", mem_req, 1'b1);
            chk("hold_we", mem_we, p_we);
            chk("hold_addr", mem_addr, p_addr);
            if (p_we) chk("hold_wdata", mem_wdata, p_wd);
         end
         if (mem_req) req_seen++;
         if (done) done_seen++;
         if (mem_req && mem_gnt) begin
            if (mem_we) begin
               obs_wr++;
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_write: addr %0d data %0d, none required", mem_addr, mem_wdata);
               end else begin
                  e = exp_q.pop_front();
                  chk("wr_addr", mem_addr, e.a);
                  chk("wr_data", mem_wdata, e.d);
               end
            end else begin
               obs_rd++;
            end
         end
         p_pend = mem_req && !mem_gnt;
         p_addr = mem_addr;
         p_we   = mem_we;
         p_wd   = mem_wdata;
      end
   end

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic set_cfg(input bit simd, input int sw, input int sh, input int dw,
                          input int dh, input int stx, input int sty);
      mode_simd  = simd;
      src_width  = DW'(sw);
      src_height = DW'(sh);
      dst_width  = DW'(dw);
      dst_height = DW'(dh);
      step_x     = 16'(stx);
      step_y     = 16'(sty);
   endtask

   task automatic run_frame(input string tag, input int exp_rd, input int exp_wr,
                            input int exp_fl, input int exp_prog, output int cyc);
      logic [31:0] f0, r0, w0;
      int          ord0, owr0, dn0, got;
      f0 = flops_count; r0 = reads_count; w0 = writes_count;
      ord0 = obs_rd; owr0 = obs_wr; dn0 = done_seen;
      pulse_start();
      cyc = 0;
      got = 0;
      while (got == 0 && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (done) got = 1;
      end
      chk({tag, "_done_seen"}, got, 1);
      repeat (4) @(negedge clk);
      chk({tag, "_done_once"}, done_seen - dn0, 1);
      chk({tag, "_writes_left"}, exp_q.size(), 0);
      chk({tag, "_bus_reads"}, obs_rd - ord0, exp_rd);
      chk({tag, "_bus_writes"}, obs_wr - owr0, exp_wr);
      chk({tag, "_reads_count"}, reads_count - r0, PERF ? exp_rd : 0);
      chk({tag, "_writes_count"}, writes_count - w0, PERF ? exp_wr : 0);
      chk({tag, "_flops_count"}, flops_count - f0, PERF ? exp_fl : 0);
      chk({tag, "_progress"}, progress, exp_prog);
      chk({tag, "_busy_idle"}, busy, 1'b0);
      exp_q.delete();
   endtask

   initial begin
      int cyc_seq, cyc_simd, cyc_tmp, owr0, dn0, req0, n;
      bit hit;
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      set_cfg(1'b0, 2, 2, 3, 3, 16'h0080, 16'h0080);
      for (int i = 0; i < 16; i++) mem[i] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_progress", progress, 0);
      chk("rst_flops", flops_count, 0);
      chk("rst_reads", reads_count, 0);
      chk("rst_writes", writes_count, 0);
      #1 rst = 1'b0;

      // Basic 2x2 -> 3x3 upscale, one pixel per group
      mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd30; mem[3] = 8'd40;
      for (int i = 0; i < 9; i++) push_wr(i, basic_vals[i]);
      set_cfg(1'b0, 2, 2, 3, 3, 16'h0080, 16'h0080);
      run_frame("basic", 36, 9, 72, 3, cyc_seq);

      // Same image, SIMD groups
      for (int i = 0; i < 9; i++) push_wr(i, basic_vals[i]);
      set_cfg(1'b1, 2, 2, 3, 3, 16'h0080, 16'h0080);
      run_frame("simd", 36, 9, 72, 3, cyc_simd);
      chk("simd_fewer_cycles", (cyc_simd < cyc_seq) ? 1 : 0, 1);

      // Stalled memory port
      stall_en = 1'b1;
      for (int i = 0; i < 9; i++) push_wr(i, basic_vals[i]);
      set_cfg(1'b0, 2, 2, 3, 3, 16'h0080, 16'h0080);
      run_frame("stall", 36, 9, 72, 3, cyc_tmp);
      stall_en = 1'b0;
      repeat (2) @(posedge clk);

      // Partial last group: 5 pixels wide, lanes 1..3 of the second group masked
      for (int i = 0; i < 5; i++) mem[i] = 8'(i + 1);
      for (int i = 0; i < 5; i++) push_wr(i, i + 1);
      set_cfg(1'b1, 5, 1, 5, 1, 16'h0100, 16'h0100);
      run_frame("partial", 20, 5, 40, 1, cyc_tmp);

      // Abort while fetching pixel (1,1)
      mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd30; mem[3] = 8'd40;
      for (int i = 0; i < 4; i++) push_wr(i, basic_vals[i]);
      set_cfg(1'b0, 2, 2, 3, 3, 16'h0080, 16'h0080);
      owr0 = obs_wr;
      dn0  = done_seen;
      pulse_start();
      hit = 1'b0;
      n = 0;
      while (!hit && n < 2000) begin
         @(negedge clk);
         n++;
         if (obs_wr - owr0 >= 4 && mem_req && !mem_we) hit = 1'b1;
      end
      chk("abort_reached_fetch", hit, 1'b1);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      chk("abort_mem_req", mem_req, 1'b0);
      chk("abort_busy", busy, 1'b0);
      repeat (10) @(negedge clk);
      chk("abort_no_done", done_seen - dn0, 0);
      chk("abort_progress", progress, 1);
      chk("abort_writes_left", exp_q.size(), 0);
      exp_q.delete();

      // Restart after abort completes normally
      for (int i = 0; i < 9; i++) push_wr(i, basic_vals[i]);
      run_frame("restart", 36, 9, 72, 3, cyc_tmp);

      // Start and abort together in IDLE: abort wins
      dn0 = done_seen;
      @(posedge clk);
      #1 begin start = 1'b1; abort = 1'b1; end
      @(posedge clk);
      #1 begin start = 1'b0; abort = 1'b0; end
      @(negedge clk);
      chk("start_abort_busy", busy, 1'b0);
      repeat (3) @(negedge clk);
      chk("start_abort_no_done", done_seen - dn0, 0);

      // Zero destination width
      req0 = req_seen;
      set_cfg(1'b0, 2, 2, 0, 3, 16'h0080, 16'h0080);
      pulse_start();
      @(negedge clk);
      chk("zero_done_c1", done, 1'b0);
      @(negedge clk);
      chk("zero_done_c2", done, 1'b1);
      @(negedge clk);
      chk("zero_done_c3", done, 1'b0);
      chk("zero_no_req", req_seen - req0, 0);
      chk("zero_busy", busy, 1'b0);
      chk("zero_progress", progress, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
